dmem_bridge: RTL and testbench

//  Parametrised data-side bus bridge between the miniRV core and its data memory / peripherals.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/dmem_bridge_if.sv | 49 ++++
 rtl/lsu_align.sv | 46 ++++
 rtl/dmem_bridge.sv | 157 +++++++++++++++
 tb/tb_dmem_bridge.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the miniRV data-side bridge: access sizes, FSM states, request record.
package bus_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_F000;
    localparam int unsigned IO_AW               = 12;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Only the fields still needed after the issue cycle are kept.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] addr_lo;
        logic       is_io;
    } req_t;

    // Reserved size 2'b11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Bundle of the core-side request/response and the memory/peripheral buses around dmem_bridge.
interface dmem_bridge_if
    import bus_pkg::*;
#(
    parameter int unsigned MEM_AW = 16
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_unsigned;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic [MEM_AW-1:0] mem_a;
    logic [3:0]        mem_we;
    logic [31:0]       mem_d;
    logic [31:0]       mem_q;

    logic              io_sel;
    logic              io_we;
    logic [IO_AW-1:0]  io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;

    // Bridge view.
    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err,
        output mem_a, mem_we, mem_d,
        input  mem_q,
        output io_sel, io_we, io_addr, io_wdata,
        input  io_rdata
    );

    // Core + memory + peripheral view.
    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        input  mem_a, mem_we, mem_d,
        output mem_q,
        input  io_sel, io_we, io_addr, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte enables, lane-replicated store data,
// load lane select with sign/zero extension, and misalignment detection.
module lsu_align
    import bus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [31:0] sh_b;
    logic [31:0] sh_h;

    always_comb begin
        sh_b         = rdata_i >> {addr_lo_i, 3'b000};
        sh_h         = rdata_i >> {addr_lo_i[1], 4'b0000};
        misaligned_o = is_misaligned(size_i, addr_lo_i);
        be_o         = 4'hF;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        unique case (size_i)
            SIZE_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns_i ? {24'h0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
            end
            SIZE_H: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns_i ? {16'h0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
            end
            default: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-side bridge between miniRV and data memory / peripheral window, with sized accesses,
// load extension and a configurable RAM read latency that stalls the core until ack.
module dmem_bridge
    import bus_pkg::*;
#(
    parameter int unsigned MEM_AW      = 16,
    parameter int unsigned READ_LAT    = 1,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    dmem_bridge_if.slave bus
);

    localparam int unsigned CntW = $clog2(READ_LAT + 1);

    state_e            state_q;
    req_t              req_q;
    logic [CntW-1:0]   cnt_q;

    logic [MEM_AW-1:0] mem_a_q;
    logic [3:0]        mem_we_q;
    logic [31:0]       mem_d_q;
    logic              io_sel_q;
    logic              io_we_q;
    logic [IO_AW-1:0]  io_addr_q;
    logic [31:0]       io_wdata_q;
    logic [31:0]       cpu_rdata_q;
    logic              cpu_ack_q;
    logic              cpu_err_q;

    logic [1:0]        al_size;
    logic              al_uns;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_raw;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic              al_mis;
    logic              req_is_io;

    // The aligner serves the incoming request in IDLE and the held request afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            al_size    = bus.cpu_size;
            al_uns     = bus.cpu_unsigned;
            al_addr_lo = bus.cpu_addr[1:0];
        end else begin
            al_size    = req_q.size;
            al_uns     = req_q.uns;
            al_addr_lo = req_q.addr_lo;
        end
        al_raw    = req_q.is_io ? bus.io_rdata : bus.mem_q;
        req_is_io = (bus.cpu_addr >= PERIPH_BASE);
    end

    lsu_align u_lsu_align (
        .size_i      (al_size),
        .uns_i       (al_uns),
        .addr_lo_i   (al_addr_lo),
        .wdata_i     (bus.cpu_wdata),
        .rdata_i     (al_raw),
        .be_o        (al_be),
        .wdata_o     (al_wdata),
        .rdata_o     (al_rdata),
        .misaligned_o(al_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            mem_a_q     <= '0;
            mem_we_q    <= '0;
            mem_d_q     <= '0;
            io_sel_q    <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle unless re-asserted below.
            mem_we_q    <= '0;
            io_sel_q    <= 1'b0;
            io_we_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        req_q <= '{we: bus.cpu_we, size: bus.cpu_size, uns: bus.cpu_unsigned,
                                   addr_lo: bus.cpu_addr[1:0], is_io: req_is_io};
                        if (al_mis) begin
                            state_q   <= RESP;
                            cpu_ack_q <= 1'b1;
                            cpu_err_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            if (req_is_io) begin
                                io_sel_q   <= 1'b1;
                                io_we_q    <= bus.cpu_we;
                                io_addr_q  <= bus.cpu_addr[IO_AW-1:0];
                                io_wdata_q <= al_wdata;
                            end else begin
                                mem_a_q  <= bus.cpu_addr[MEM_AW+1:2];
                                mem_we_q <= bus.cpu_we ? al_be : 4'h0;
                                mem_d_q  <= al_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (req_q.we || req_q.is_io) begin
                        state_q     <= RESP;
                        cpu_ack_q   <= 1'b1;
                        cpu_rdata_q <= req_q.we ? 32'h0 : al_rdata;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CntW'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    // Last WAIT cycle is the one where mem_q holds the addressed word.
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        cpu_ack_q   <= 1'b1;
                        cpu_rdata_q <= al_rdata;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a     = mem_a_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.io_sel    = io_sel_q;
    assign bus.io_we     = io_we_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: two instances (read latency 1 and 3) with behavioural RAMs.
module tb_dmem_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] io_rd0 = 32'h0;

    logic [31:0] ram0 [0:63];
    logic [31:0] ram1 [0:63];
    logic [31:0] pipe0;
    logic [31:0] pipe1 [0:2];

    dmem_bridge_if #(.MEM_AW(16)) b0 ();
    dmem_bridge_if #(.MEM_AW(16)) b1 ();

    dmem_bridge #(.MEM_AW(16), .READ_LAT(1), .PERIPH_BASE(32'hFFFF_F000)) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0)
    );

    dmem_bridge #(.MEM_AW(16), .READ_LAT(3), .PERIPH_BASE(32'hFFFF_F000)) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAMs: mem_q presents the word READ_LAT cycles after it is addressed.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (b0.mem_we[i]) ram0[b0.mem_a[5:0]][8*i +: 8] <= b0.mem_d[8*i +: 8];
        pipe0 <= ram0[b0.mem_a[5:0]];
    end

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (b1.mem_we[j]) ram1[b1.mem_a[5:0]][8*j +: 8] <= b1.mem_d[8*j +: 8];
        pipe1[0] <= ram1[b1.mem_a[5:0]];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    assign b0.mem_q    = pipe0;
    assign b0.io_rdata = io_rd0;
    assign b1.mem_q    = pipe1[2];
    assign b1.io_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon_one(input int d, input logic ack, input logic err,
                           input logic [31:0] rd, inout logic prev);
        exp_t e;
        if (ack) begin
            chk($sformatf("ack_consecutive_%0d", d), 32'(prev), 32'h0);
            if (qsize(d) == 0) begin
                chk($sformatf("unexpected_ack_%0d", d), 32'(ack), 32'h0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("ack_cycle_%0d", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("err_%0d", d), 32'(err), 32'(e.err));
                if (e.chk_rd) chk($sformatf("rdata_%0d", d), rd, e.rdata);
            end
        end
        prev = ack;
    endtask

    task automatic monitor();
        logic p0 = 1'b0;
        logic p1 = 1'b0;
        forever begin
            @(negedge clk);
            mon_one(0, b0.cpu_ack, b0.cpu_err, b0.cpu_rdata, p0);
            mon_one(1, b1.cpu_ack, b1.cpu_err, b1.cpu_rdata, p1);
        end
    endtask

    task automatic drive(input int d, input logic req, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.cpu_req = req; b0.cpu_we = we; b0.cpu_size = sz;
            b0.cpu_unsigned = uns; b0.cpu_addr = a; b0.cpu_wdata = wd;
        end else begin
            b1.cpu_req = req; b1.cpu_we = we; b1.cpu_size = sz;
            b1.cpu_unsigned = uns; b1.cpu_addr = a; b1.cpu_wdata = wd;
        end
    endtask

    // Issues one request; returns 1ns into the issue cycle (T+1).
    task automatic send(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic want_ack);
        exp_t e;
        int   lat;
        @(posedge clk);
        #1;
        drive(d, 1'b1, we, sz, uns, a, wd);
        if (exp_err) lat = 1;
        else if (we || a >= 32'hFFFF_F000) lat = 2;
        else lat = (d == 0) ? 3 : 5;
        e.rdata  = exp_rd;
        e.chk_rd = !we || exp_err;
        e.err    = exp_err;
        e.cyc    = cyc + lat;
        if (want_ack) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_done(input int d);
        for (int k = 0; k < 40 && qsize(d) != 0; k++) @(posedge clk);
        if (qsize(d) != 0) begin
            chk($sformatf("ack_timeout_%0d", d), 32'(qsize(d)), 32'h0);
            if (d == 0) q0.delete();
            else q1.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor();
        join_none
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(b0.mem_we), 32'h0);
        chk("rst_io_sel", 32'(b0.io_sel), 32'h0);
        chk("rst_ack", 32'(b0.cpu_ack), 32'h0);
        chk("rst_rdata", b0.cpu_rdata, 32'h0);
        chk("rst_mem_a", 32'(b0.mem_a), 32'h0);
        #2 rst_n = 1'b1;

        // Word store and byte/half lanes on the latency-1 instance.
        send(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
        chk("sw_mem_a", 32'(b0.mem_a), 32'h4);
        chk("sw_mem_we", 32'(b0.mem_we), 32'hF);
        chk("sw_mem_d", b0.mem_d, 32'hDEADBEEF);
        chk("sw_io_sel", 32'(b0.io_sel), 32'h0);
        wait_done(0);
        send(0, 1, 2'b00, 0, 32'h13, 32'h000000A5, 32'h0, 0, 1);
        chk("sb_mem_we", 32'(b0.mem_we), 32'h8);
        chk("sb_mem_d", b0.mem_d, 32'hA5A5A5A5);
        wait_done(0);
        send(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 1);
        chk("lb_mem_we", 32'(b0.mem_we), 32'h0);
        chk("lb_mem_a", 32'(b0.mem_a), 32'h4);
        wait_done(0);
        send(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000A5, 0, 1);
        wait_done(0);
        send(0, 1, 2'b01, 0, 32'h12, 32'h00001234, 32'h0, 0, 1);
        chk("sh_mem_we", 32'(b0.mem_we), 32'hC);
        chk("sh_mem_d", b0.mem_d, 32'h12341234);
        wait_done(0);
        send(0, 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 1);
        wait_done(0);
        send(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0, 1);
        wait_done(0);
        send(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0, 1);
        wait_done(0);
        send(0, 0, 2'b11, 1, 32'h10, 32'h0, 32'h1234BEEF, 0, 1);
        wait_done(0);

        // Misaligned accesses: immediate error, no bus activity.
        send(0, 0, 2'b10, 0, 32'h6, 32'h0, 32'h0, 1, 1);
        chk("mis_lw_mem_we", 32'(b0.mem_we), 32'h0);
        chk("mis_lw_io_sel", 32'(b0.io_sel), 32'h0);
        wait_done(0);
        send(0, 1, 2'b01, 0, 32'h3, 32'hFFFF, 32'h0, 1, 1);
        chk("mis_sh_mem_we", 32'(b0.mem_we), 32'h0);
        chk("mis_sh_io_sel", 32'(b0.io_sel), 32'h0);
        wait_done(0);

        // Peripheral window and the address just below it.
        io_rd0 = 32'h12345678;
        send(0, 1, 2'b10, 0, 32'hFFFFF004, 32'hCAFEF00D, 32'h0, 0, 1);
        chk("io_sw_sel", 32'(b0.io_sel), 32'h1);
        chk("io_sw_we", 32'(b0.io_we), 32'h1);
        chk("io_sw_addr", 32'(b0.io_addr), 32'h004);
        chk("io_sw_wdata", b0.io_wdata, 32'hCAFEF00D);
        chk("io_sw_mem_we", 32'(b0.mem_we), 32'h0);
        wait_done(0);
        send(0, 0, 2'b10, 0, 32'hFFFFF000, 32'h0, 32'h12345678, 0, 1);
        chk("io_lw_sel", 32'(b0.io_sel), 32'h1);
        chk("io_lw_we", 32'(b0.io_we), 32'h0);
        chk("io_lw_mem_we", 32'(b0.mem_we), 32'h0);
        wait_done(0);
        io_rd0 = 32'h12348056;
        send(0, 0, 2'b00, 0, 32'hFFFFF001, 32'h0, 32'hFFFFFF80, 0, 1);
        wait_done(0);
        send(0, 1, 2'b10, 0, 32'hFFFFEFFC, 32'h0BADF00D, 32'h0, 0, 1);
        chk("edge_io_sel", 32'(b0.io_sel), 32'h0);
        chk("edge_mem_we", 32'(b0.mem_we), 32'hF);
        chk("edge_mem_a", 32'(b0.mem_a), 32'hFBFF);
        wait_done(0);
        send(0, 0, 2'b10, 0, 32'hFFFFEFFC, 32'h0, 32'h0BADF00D, 0, 1);
        wait_done(0);

        // Latency-3 instance: preload, then reset mid-store and mid-wait.
        send(1, 1, 2'b10, 0, 32'h10, 32'h80010000, 32'h0, 0, 1);
        wait_done(1);
        send(1, 1, 2'b10, 0, 32'h20, 32'h11111111, 32'h0, 0, 0);
        chk("kill_st_pre_we", 32'(b1.mem_we), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        chk("kill_st_mem_we", 32'(b1.mem_we), 32'h0);
        chk("kill_st_io_sel", 32'(b1.io_sel), 32'h0);
        chk("kill_st_mem_d", b1.mem_d, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        send(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("kill_ld_mem_a", 32'(b1.mem_a), 32'h0);
        chk("kill_ld_ack", 32'(b1.cpu_ack), 32'h0);
        chk("kill_ld_rdata", b1.cpu_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);

        send(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8001, 0, 1);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("lh_mem_a_T%0d", s + 1), 32'(b1.mem_a), 32'h4);
            @(posedge clk);
            #1;
        end
        wait_done(1);
        send(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h00008001, 0, 1);
        wait_done(1);
        send(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80010000, 0, 1);
        wait_done(1);
        send(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1);
        wait_done(1);
        send(1, 0, 2'b00, 0, 32'h10, 32'h0, 32'h00000000, 0, 1);
        wait_done(1);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
